dual_issue_fetch_queue: RTL and testbench
=========================================

# dual_issue_fetch_queue

- Buffers fetched instruction pairs between instruction memory and the two decode lanes of the dual-issue pipeline.
- Presents the head pair to decode lanes 1 and 2.
- Obeys the hazard unit's decode stall and flush controls.
- Serializes a pair into two single-lane issues when an intra-pair dependency is flagged.

## Interface
Parameters:
- DEPTH, 4, number of pair entries; power of two, ≥2
- NOP, 32'h00000013, instruction word driven on an invalid lane

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- FetchValid  in  1  fetch offers a pair this cycle
- FetchPC  in  32  PC of first instruction of pair; second is FetchPC+4
- FetchInstr1  in  32  instruction at FetchPC
- FetchInstr2  in  32  instruction at FetchPC+4
- FetchReady  out  1  queue accepts a pair this cycle
- StallD  in  1  decode holds; nothing is consumed
- SplitD  in  1  issue lane 1 only, then re-present the second instruction on lane 1
- FlushD  in  1  discard all buffered and presented instructions (taken branch/jump)
- ValidD1  out  1  lane 1 holds a real instruction
- InstrD1  out  32  lane 1 instruction
- PCD1  out  32  lane 1 PC
- ValidD2  out  1  lane 2 holds a real instruction
- InstrD2  out  32  lane 2 instruction
- PCD2  out  32  lane 2 PC
- Count  out  $clog2(DEPTH)+1  occupied entries

## Operation
Storage:
- Circular array of DEPTH entries {PC, Instr1, Instr2}, with read pointer, write pointer and occupancy count.
- Head state bit Half: 0 means both instructions are pending; 1 means only Instr2 is pending.

Outputs (functions of registered state only; no input-to-output combinational path):
- ValidD1 = Count≠0.
- InstrD1/PCD1 = Half ? (Instr2, PC+4) : (Instr1, PC).
- ValidD2 = Count≠0 && !Half.
- InstrD2 = Instr2; PCD2 = PC+4.
- Invalid lane: instruction = NOP, PC = 0.
- FetchReady = Count<DEPTH. There is no bypass: a full queue refuses even if a pop occurs the same cycle.

Per-cycle update, in priority order:
- FlushD=1: pointers, Count and Half are cleared; the fetch offer this cycle is dropped. StallD and SplitD are ignored.
- Pop (Count≠0 && !StallD):
  - Half=0 with SplitD=1: Half←1, no pointer change.
  - Otherwise: read pointer +1, Half←0.
  - SplitD while Half=1 is ignored.
- Push (FetchValid && FetchReady && !FlushD): write at write pointer, write pointer +1.
- Count tracks push minus pop, including a simultaneous push and pop.
- Pointers wrap modulo DEPTH.

Reset:
- All pointers, Count and Half are 0.
- ValidD1 = ValidD2 = 0; InstrD1 = InstrD2 = NOP; PC outputs = 0; FetchReady = 1.
- Reset asserted mid-operation discards all contents immediately (asynchronous clear).

## Timing
- Push-to-present latency: 1 cycle. A pair accepted at edge N appears on the lanes after edge N if the queue was empty.
- Throughput: one pair per cycle when neither StallD nor SplitD is asserted.
- A split pair occupies the head for 2 consecutive unstalled cycles.
- StallD on the second half holds the lone instruction on lane 1.
- Flush: lanes show invalid/NOP from the cycle after the FlushD edge. The first redirected pair appears one cycle after it is pushed.
- Simultaneous flush and push: the push is dropped and the queue is empty afterwards.
- Simultaneous push and pop at Count=DEPTH-1: Count stays DEPTH-1 and ordering is preserved.

## Structure
- Shared package dual_issue_pkg holds:
  - the NOP constant
  - the fetch_pair_t struct {pc, instr1, instr2}
- Storage, pointers and Half live in this module; no sub-module is needed.

## Test plan
- Reset: assert rst mid-stream with Count=3 → immediately ValidD1=0, ValidD2=0, InstrD1=NOP, Count=0, FetchReady=1.
- Streaming: push PC 0x100/0x108/0x110 on consecutive cycles with no stall → lanes show (0x100, 0x104), (0x108, 0x10C), (0x110, 0x114) on consecutive cycles.
- Full: hold StallD, push 5 pairs → Count=4 and FetchReady=0 after the 4th; 5th is refused; release StallD → order preserved, 0x100 first.
- Split: head PC 0x200, SplitD=1 for one cycle → cycle 1: lane 1 = 0x200, lane 2 valid; cycle 2: lane 1 = 0x204, ValidD2=0; cycle 3: next pair.
- Flush: Count=3, FlushD with simultaneous FetchValid (PC 0x300) → next cycle Count=0, lanes invalid; push 0x400 → lanes show 0x400 one cycle later.
- Wrap: 2·DEPTH+1 pushes interleaved with pops and stalls → every PC appears exactly once, in order, and Count never exceeds DEPTH.

Source files
------------

// File: rtl/dual_issue_pkg.sv
// Shared types and constants for the dual-issue front end.
package dual_issue_pkg;

   // addi x0, x0, 0 -- the word shown on a lane that carries no instruction
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr1;
      logic [31:0] instr2;
   } fetch_pair_t;

endpackage

// File: rtl/dual_issue_fetch_queue.sv
// Fetch queue feeding the two decode lanes. Holds instruction pairs, presents
// the head pair, and can issue a pair as two single-lane issues (Half bit).
module dual_issue_fetch_queue
   import dual_issue_pkg::*;
#(
   parameter int          DEPTH = 4,
   parameter logic [31:0] NOP   = NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     FetchValid,
   input  logic [31:0]              FetchPC,
   input  logic [31:0]              FetchInstr1,
   input  logic [31:0]              FetchInstr2,
   output logic                     FetchReady,
   input  logic                     StallD,
   input  logic                     SplitD,
   input  logic                     FlushD,
   output logic                     ValidD1,
   output logic [31:0]              InstrD1,
   output logic [31:0]              PCD1,
   output logic                     ValidD2,
   output logic [31:0]              InstrD2,
   output logic [31:0]              PCD2,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_pair_t   mem_q [DEPTH];
   fetch_pair_t   head;
   logic [31:0]   head_pc4;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          half_q, half_d;
   logic          not_empty;
   logic          pop;
   logic          split_first;
   logic          advance;
   logic          push;

   assign not_empty   = (count_q != '0);
   // No bypass: a full queue refuses even when the head leaves this cycle.
   assign FetchReady  = (count_q < CW'(DEPTH));
   assign pop         = not_empty && !StallD && !FlushD;
   // A split on the first half only flips Half; SplitD on the second half is a no-op.
   assign split_first = pop && !half_q && SplitD;
   assign advance     = pop && !split_first;
   assign push        = FetchValid && FetchReady && !FlushD;
   assign Count       = count_q;

   // Next-state for pointers, occupancy and head half; flush has priority.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      half_d   = half_q;
      if (FlushD) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         half_d   = 1'b0;
      end else begin
         if (split_first) begin
            half_d = 1'b1;
         end else if (advance) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            half_d   = 1'b0;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(advance);
      end
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         half_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         half_q   <= half_d;
      end
   end

   // Pair storage; contents are only meaningful while covered by Count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{pc: FetchPC, instr1: FetchInstr1, instr2: FetchInstr2};
      end
   end

   // Lane outputs are decoded purely from registered state.
   always_comb begin
      head     = mem_q[rd_ptr_q];
      head_pc4 = head.pc + 32'd4;
      ValidD1  = 1'b0;
      InstrD1  = NOP;
      PCD1     = '0;
      ValidD2  = 1'b0;
      InstrD2  = NOP;
      PCD2     = '0;
      if (not_empty) begin
         ValidD1 = 1'b1;
         if (half_q) begin
            InstrD1 = head.instr2;
            PCD1    = head_pc4;
         end else begin
            InstrD1 = head.instr1;
            PCD1    = head.pc;
            ValidD2 = 1'b1;
            InstrD2 = head.instr2;
            PCD2    = head_pc4;
         end
      end
   end

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Scoreboard bench for dual_issue_fetch_queue: the driver queues the lane
// contents it expects to see issued, the monitor compares on every consumed cycle.
module tb_dual_issue_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOPW  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        FetchValid;
   logic [31:0] FetchPC, FetchInstr1, FetchInstr2;
   logic        FetchReady;
   logic        StallD, SplitD, FlushD;
   logic        ValidD1, ValidD2;
   logic [31:0] InstrD1, PCD1, InstrD2, PCD2;
   logic [$clog2(DEPTH):0] Count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v2;
      logic [31:0] pc1, i1, pc2, i2;
   } exp_t;
   exp_t exp_q[$];

   dual_issue_fetch_queue #(.DEPTH(DEPTH), .NOP(NOPW)) dut (
      .clk(clk), .rst(rst),
      .FetchValid(FetchValid), .FetchPC(FetchPC),
      .FetchInstr1(FetchInstr1), .FetchInstr2(FetchInstr2),
      .FetchReady(FetchReady),
      .StallD(StallD), .SplitD(SplitD), .FlushD(FlushD),
      .ValidD1(ValidD1), .InstrD1(InstrD1), .PCD1(PCD1),
      .ValidD2(ValidD2), .InstrD2(InstrD2), .PCD2(PCD2),
      .Count(Count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ia(input logic [31:0] pc);
      return 32'hA000_0000 | pc;
   endfunction

   function automatic logic [31:0] ib(input logic [31:0] pc);
      return 32'hB000_0000 | pc;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic offer(input logic [31:0] pc);
      FetchValid  = 1'b1;
      FetchPC     = pc;
      FetchInstr1 = ia(pc);
      FetchInstr2 = ib(pc);
   endtask

   task automatic exp_pair(input logic [31:0] pc);
      exp_q.push_back('{v2: 1'b1, pc1: pc, i1: ia(pc), pc2: pc + 32'd4, i2: ib(pc)});
   endtask

   task automatic exp_split(input logic [31:0] pc);
      exp_q.push_back('{v2: 1'b1, pc1: pc, i1: ia(pc), pc2: pc + 32'd4, i2: ib(pc)});
      exp_q.push_back('{v2: 1'b0, pc1: pc + 32'd4, i1: ib(pc), pc2: 32'd0, i2: NOPW});
   endtask

   task automatic drain();
      int n = 0;
      FetchValid = 1'b0;
      StallD     = 1'b0;
      SplitD     = 1'b0;
      while (Count != 0 && n < 50) begin
         cyc();
         n++;
      end
      checks++;
      if (Count != 0) begin
         errors++;
         $display("FAIL drain_timeout: count %0d expected 0", Count);
      end
   endtask

   // Monitor: a presented head is consumed on any unstalled, unflushed cycle.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (Count > DEPTH) begin
            errors++;
            $display("FAIL count_bound: count %0d exceeds %0d", Count, DEPTH);
         end
         if (ValidD1 && !StallD && !FlushD) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue: pc1 %h with empty scoreboard", PCD1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (PCD1 !== e.pc1 || InstrD1 !== e.i1 || ValidD2 !== e.v2 ||
                   PCD2 !== e.pc2 || InstrD2 !== e.i2) begin
                  errors++;
                  $display("FAIL issue: got pc1 %h i1 %h v2 %b pc2 %h i2 %h expected pc1 %h i1 %h v2 %b pc2 %h i2 %h",
                           PCD1, InstrD1, ValidD2, PCD2, InstrD2, e.pc1, e.i1, e.v2, e.pc2, e.i2);
               end
            end
         end
      end
   end

   initial begin
      int pushed;
      logic acc;
      rst = 1'b1;
      FetchValid = 1'b0; FetchPC = '0; FetchInstr1 = '0; FetchInstr2 = '0;
      StallD = 1'b0; SplitD = 1'b0; FlushD = 1'b0;
      #22;
      chk("reset_valid1", 32'(ValidD1), 32'd0);
      chk("reset_instr1", InstrD1, NOPW);
      chk("reset_instr2", InstrD2, NOPW);
      chk("reset_pc1", PCD1, 32'd0);
      chk("reset_ready", 32'(FetchReady), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      cyc();

      // streaming, one pair per cycle
      offer(32'h100); exp_pair(32'h100); cyc();
      chk("stream_pc_a", PCD1, 32'h100);
      chk("stream_pc2_a", PCD2, 32'h104);
      offer(32'h108); exp_pair(32'h108); cyc();
      chk("stream_pc_b", PCD1, 32'h108);
      offer(32'h110); exp_pair(32'h110); cyc();
      FetchValid = 1'b0;
      chk("stream_pc_c", PCD1, 32'h110);
      chk("stream_pc2_c", PCD2, 32'h114);
      drain();

      // fill under stall, fifth offer refused
      StallD = 1'b1;
      for (int k = 0; k < 5; k++) begin
         offer(32'h100 + 32'(8 * k));
         if (k < 4) exp_pair(32'h100 + 32'(8 * k));
         cyc();
         if (k == 3) begin
            chk("full_count", 32'(Count), 32'd4);
            chk("full_ready", 32'(FetchReady), 32'd0);
         end
      end
      FetchValid = 1'b0;
      chk("full_refused_count", 32'(Count), 32'd4);
      chk("full_head", PCD1, 32'h100);
      drain();

      // split then next pair
      StallD = 1'b1;
      offer(32'h200); exp_split(32'h200); cyc();
      offer(32'h208); exp_pair(32'h208); cyc();
      FetchValid = 1'b0; StallD = 1'b0; SplitD = 1'b1;
      chk("split_c1_pc", PCD1, 32'h200);
      chk("split_c1_v2", 32'(ValidD2), 32'd1);
      cyc();
      SplitD = 1'b0;
      chk("split_c2_pc", PCD1, 32'h204);
      chk("split_c2_instr", InstrD1, ib(32'h200));
      chk("split_c2_v2", 32'(ValidD2), 32'd0);
      cyc();
      chk("split_c3_pc", PCD1, 32'h208);
      drain();

      // stall on the second half holds the lone instruction
      StallD = 1'b1;
      offer(32'h210); exp_split(32'h210); cyc();
      FetchValid = 1'b0; StallD = 1'b0; SplitD = 1'b1;
      cyc();
      SplitD = 1'b0; StallD = 1'b1;
      cyc();
      chk("half_stall_pc", PCD1, 32'h214);
      chk("half_stall_v1", 32'(ValidD1), 32'd1);
      chk("half_stall_v2", 32'(ValidD2), 32'd0);
      drain();

      // flush with a simultaneous fetch offer
      StallD = 1'b1;
      for (int k = 0; k < 3; k++) begin
         offer(32'h280 + 32'(8 * k)); cyc();
      end
      chk("flush_pre_count", 32'(Count), 32'd3);
      StallD = 1'b0; FlushD = 1'b1; offer(32'h300);
      exp_q.delete();
      cyc();
      FlushD = 1'b0; FetchValid = 1'b0;
      chk("flush_count", 32'(Count), 32'd0);
      chk("flush_v1", 32'(ValidD1), 32'd0);
      chk("flush_v2", 32'(ValidD2), 32'd0);
      chk("flush_instr1", InstrD1, NOPW);
      offer(32'h400); exp_pair(32'h400); cyc();
      FetchValid = 1'b0;
      chk("redirect_pc", PCD1, 32'h400);
      drain();

      // asynchronous reset mid-stream
      StallD = 1'b1;
      for (int k = 0; k < 3; k++) begin
         offer(32'h600 + 32'(8 * k)); cyc();
      end
      FetchValid = 1'b0;
      chk("rst_pre_count", 32'(Count), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("rst_mid_v1", 32'(ValidD1), 32'd0);
      chk("rst_mid_v2", 32'(ValidD2), 32'd0);
      chk("rst_mid_instr1", InstrD1, NOPW);
      chk("rst_mid_count", 32'(Count), 32'd0);
      chk("rst_mid_ready", 32'(FetchReady), 32'd1);
      @(negedge clk);
      rst = 1'b0; StallD = 1'b0;
      cyc();

      // wrap: 2*DEPTH+1 pushes with interleaved stalls
      pushed = 0;
      for (int t = 0; t < 80 && pushed < 2 * DEPTH + 1; t++) begin
         offer(32'h500 + 32'(8 * pushed));
         StallD = ((t % 5) >= 1 && (t % 5) <= 3);
         acc = FetchReady;
         if (acc) exp_pair(32'h500 + 32'(8 * pushed));
         cyc();
         if (acc) pushed++;
      end
      chk("wrap_pushed", 32'(pushed), 32'(2 * DEPTH + 1));
      drain();
      cyc();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
